// File: rtl/mult_axi_pkg.sv
// Shared constants for the multiplier AXI-Lite initiator: FSM encoding,
// default register byte offsets of the multiplier slave, and the OKAY response.
// No logic; imported by mult_axi_master and axi_lite_wr_channel.
package mult_axi_pkg;

  // FSM state encoding (one write or read phase per state)
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_WR_A       = 4'd1;
  localparam logic [3:0] ST_WR_A_RESP  = 4'd2;
  localparam logic [3:0] ST_WR_B       = 4'd3;
  localparam logic [3:0] ST_WR_B_RESP  = 4'd4;
  localparam logic [3:0] ST_RD_LO      = 4'd5;
  localparam logic [3:0] ST_RD_LO_DATA = 4'd6;
  localparam logic [3:0] ST_RD_HI      = 4'd7;
  localparam logic [3:0] ST_RD_HI_DATA = 4'd8;
  localparam logic [3:0] ST_DONE       = 4'd9;

  // Default byte offsets of the multiplier slave registers
  localparam int unsigned DEF_ADDR_OP_A   = 16;
  localparam int unsigned DEF_ADDR_OP_B   = 20;
  localparam int unsigned DEF_ADDR_RES_LO = 24;
  localparam int unsigned DEF_ADDR_RES_HI = 28;

  // bresp/rresp value meaning success
  localparam logic RESP_OKAY = 1'b0;

endpackage

// File: rtl/axi_lite_wr_channel.sv
// AXI-Lite AW+W issuer: launches one address/data pair per start pulse.
// Latency: valids rise the cycle after start; done pulses in the cycle the last of AW/W handshakes.
// Backpressure: awvalid and wvalid each hold (payload stable) until their own ready, then drop independently.
// Ports: clk/rst_n (sync active-low), start + start_addr/start_data (load a new write),
//        awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, done (both channels complete).
module axi_lite_wr_channel
  import mult_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     start_addr,
  input  logic [DATA_WIDTH-1:0]     start_data,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  output logic                      done
);

  logic busy;

  // Complete once neither channel is still waiting; a channel finishing in
  // this very cycle counts, so AW and W may close in either order or together.
  assign done = busy && (!awvalid || awready) && (!wvalid || wready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      busy    <= 1'b0;
    end else if (start) begin
      awaddr  <= start_addr;
      awvalid <= 1'b1;
      wdata   <= start_data;
      wstrb   <= '1;
      wvalid  <= 1'b1;
      busy    <= 1'b1;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (done)               busy    <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_axi_master.sv
// AXI-Lite initiator for the multiplier: writes op A, op B, reads result lo/hi, returns product.
// Latency: 9 cycles from command handshake to res_valid with a zero-wait, next-cycle slave.
// Backpressure: one command at a time; cmd_ready only in IDLE, result held in DONE until res_ready.
// Ports: m2_axi_aclk/m2_axi_aresetn (sync active-low), cmd_* command in, res_* result out,
//        m2_axi_aw*/w*/b* write channels, m2_axi_ar*/r* read channels.
module mult_axi_master
  import mult_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned ADDR_OP_A   = DEF_ADDR_OP_A,
  parameter int unsigned ADDR_OP_B   = DEF_ADDR_OP_B,
  parameter int unsigned ADDR_RES_LO = DEF_ADDR_RES_LO,
  parameter int unsigned ADDR_RES_HI = DEF_ADDR_RES_HI
) (
  input  logic                      m2_axi_aclk,
  input  logic                      m2_axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DATA_WIDTH-1:0]     cmd_op_a,
  input  logic [DATA_WIDTH-1:0]     cmd_op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_product,
  output logic                      res_err,
  output logic [ADDR_WIDTH-1:0]     m2_axi_awaddr,
  output logic                      m2_axi_awvalid,
  input  logic                      m2_axi_awready,
  output logic [DATA_WIDTH-1:0]     m2_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m2_axi_wstrb,
  output logic                      m2_axi_wvalid,
  input  logic                      m2_axi_wready,
  input  logic                      m2_axi_bresp,
  input  logic                      m2_axi_bvalid,
  output logic                      m2_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m2_axi_araddr,
  output logic                      m2_axi_arvalid,
  input  logic                      m2_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m2_axi_rdata,
  input  logic                      m2_axi_rresp,
  input  logic                      m2_axi_rvalid,
  output logic                      m2_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] A_OP_A   = ADDR_WIDTH'(ADDR_OP_A);
  localparam logic [ADDR_WIDTH-1:0] A_OP_B   = ADDR_WIDTH'(ADDR_OP_B);
  localparam logic [ADDR_WIDTH-1:0] A_RES_LO = ADDR_WIDTH'(ADDR_RES_LO);
  localparam logic [ADDR_WIDTH-1:0] A_RES_HI = ADDR_WIDTH'(ADDR_RES_HI);

  logic [3:0]            state;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] res_lo;
  logic [DATA_WIDTH-1:0] res_hi;
  logic                  err;

  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;

  logic b_ok;
  logic r_ok;

  assign b_ok = (m2_axi_bresp == RESP_OKAY);
  assign r_ok = (m2_axi_rresp == RESP_OKAY);

  // Handshake-side outputs are pure state decodes; none looks at its own ready.
  assign cmd_ready     = (state == ST_IDLE);
  assign res_valid     = (state == ST_DONE);
  assign m2_axi_bready = (state == ST_WR_A_RESP) || (state == ST_WR_B_RESP);
  assign m2_axi_rready = (state == ST_RD_LO_DATA) || (state == ST_RD_HI_DATA);
  assign res_product   = {res_hi, res_lo};
  assign res_err       = err;

  // Operand A goes straight from the command port into the write channel at
  // acceptance, so only operand B needs a holding register.
  always_comb begin
    wr_start = 1'b0;
    wr_addr  = A_OP_A;
    wr_data  = cmd_op_a;
    if (state == ST_IDLE) begin
      wr_start = cmd_valid;
    end else if (state == ST_WR_A_RESP) begin
      wr_start = m2_axi_bvalid && b_ok;
      wr_addr  = A_OP_B;
      wr_data  = op_b;
    end
  end

  axi_lite_wr_channel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr (
    .clk        (m2_axi_aclk),
    .rst_n      (m2_axi_aresetn),
    .start      (wr_start),
    .start_addr (wr_addr),
    .start_data (wr_data),
    .awaddr     (m2_axi_awaddr),
    .awvalid    (m2_axi_awvalid),
    .awready    (m2_axi_awready),
    .wdata      (m2_axi_wdata),
    .wstrb      (m2_axi_wstrb),
    .wvalid     (m2_axi_wvalid),
    .wready     (m2_axi_wready),
    .done       (wr_done)
  );

  always_ff @(posedge m2_axi_aclk) begin
    if (!m2_axi_aresetn) begin
      state          <= ST_IDLE;
      op_b           <= '0;
      res_lo         <= '0;
      res_hi         <= '0;
      err            <= 1'b0;
      m2_axi_arvalid <= 1'b0;
      m2_axi_araddr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_b   <= cmd_op_b;
            // Halves not captured before an error must read back as zero.
            res_lo <= '0;
            res_hi <= '0;
            err    <= 1'b0;
            state  <= ST_WR_A;
          end
        end
        ST_WR_A: begin
          if (wr_done) state <= ST_WR_A_RESP;
        end
        ST_WR_A_RESP: begin
          if (m2_axi_bvalid) begin
            if (b_ok) begin
              state <= ST_WR_B;
            end else begin
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_WR_B: begin
          if (wr_done) state <= ST_WR_B_RESP;
        end
        ST_WR_B_RESP: begin
          if (m2_axi_bvalid) begin
            if (b_ok) begin
              m2_axi_arvalid <= 1'b1;
              m2_axi_araddr  <= A_RES_LO;
              state          <= ST_RD_LO;
            end else begin
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RD_LO: begin
          if (m2_axi_arready) begin
            m2_axi_arvalid <= 1'b0;
            state          <= ST_RD_LO_DATA;
          end
        end
        ST_RD_LO_DATA: begin
          if (m2_axi_rvalid) begin
            if (r_ok) begin
              res_lo         <= m2_axi_rdata;
              m2_axi_arvalid <= 1'b1;
              m2_axi_araddr  <= A_RES_HI;
              state          <= ST_RD_HI;
            end else begin
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RD_HI: begin
          if (m2_axi_arready) begin
            m2_axi_arvalid <= 1'b0;
            state          <= ST_RD_HI_DATA;
          end
        end
        ST_RD_HI_DATA: begin
          if (m2_axi_rvalid) begin
            if (r_ok) res_hi <= m2_axi_rdata;
            else      err    <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            err   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_axi_master.sv
// Bench for mult_axi_master: reactive AXI-Lite multiplier slave model,
// command driver, and result scoreboard fed with operand products.
// Slave readiness/latency and error injection are tunable per test.
module tb_mult_axi_master;

  logic        clk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op_a;
  logic [31:0] cmd_op_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_product;
  logic        res_err;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;

  mult_axi_master dut (
    .m2_axi_aclk    (clk),
    .m2_axi_aresetn (aresetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op_a       (cmd_op_a),
    .cmd_op_b       (cmd_op_b),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_product    (res_product),
    .res_err        (res_err),
    .m2_axi_awaddr  (awaddr),
    .m2_axi_awvalid (awvalid),
    .m2_axi_awready (awready),
    .m2_axi_wdata   (wdata),
    .m2_axi_wstrb   (wstrb),
    .m2_axi_wvalid  (wvalid),
    .m2_axi_wready  (wready),
    .m2_axi_bresp   (bresp),
    .m2_axi_bvalid  (bvalid),
    .m2_axi_bready  (bready),
    .m2_axi_araddr  (araddr),
    .m2_axi_arvalid (arvalid),
    .m2_axi_arready (arready),
    .m2_axi_rdata   (rdata),
    .m2_axi_rresp   (rresp),
    .m2_axi_rvalid  (rvalid),
    .m2_axi_rready  (rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int   aw_delay = 0;
  int   w_delay  = 0;
  int   r_delay  = 0;
  logic [7:0] err_addr = 8'hFF;

  logic [31:0] reg_a, reg_b;
  logic        got_aw, got_w, r_pend;
  logic [7:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  int          aw_cnt, w_cnt, r_wait, ar_count;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wstrb_q[$];
  logic [7:0]  rd_addr_q[$];

  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [63:0] prod;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    reg_a = 0; reg_b = 0; got_aw = 0; got_w = 0; r_pend = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0;
    aw_cnt = 0; w_cnt = 0; r_wait = 0; ar_count = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (aw_hs) begin
        got_aw = 1; s_awaddr = awaddr; aw_cnt = 0; wr_addr_q.push_back(awaddr);
      end else if (awvalid) aw_cnt++;
      if (w_hs) begin
        got_w = 1; s_wdata = wdata; w_cnt = 0;
        wr_data_q.push_back(wdata); wstrb_q.push_back(wstrb);
      end else if (wvalid) w_cnt++;
      if (ar_hs) begin
        s_araddr = araddr; r_pend = 1; r_wait = r_delay;
        rd_addr_q.push_back(araddr); ar_count++;
      end
      @(posedge clk);
      #1;
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        got_aw = 0; got_w = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (b_hs) bvalid = 0;
      if (got_aw && got_w) begin
        if (s_awaddr == 8'd16) reg_a = s_wdata;
        if (s_awaddr == 8'd20) reg_b = s_wdata;
        bresp  = (s_awaddr == err_addr);
        bvalid = 1;
        got_aw = 0; got_w = 0;
      end
      if (r_hs) rvalid = 0;
      if (r_pend) begin
        if (r_wait == 0) begin
          prod   = {32'd0, reg_a} * {32'd0, reg_b};
          rdata  = (s_araddr == 8'd24) ? prod[31:0] : prod[63:32];
          rresp  = 0;
          rvalid = 1;
          r_pend = 0;
        end else r_wait--;
      end
      awready = awvalid && (aw_cnt >= aw_delay);
      wready  = wvalid && (w_cnt >= w_delay);
      arready = arvalid;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [63:0] prod; logic err; } exp_t;
  exp_t exp_q[$];
  int   n_res = 0;
  int   n_rise = 0;
  int   rise_cyc = 0;
  int   res_hs_cyc = 0;
  int   acc_cyc = 0;
  logic prev_rv = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid && !prev_rv) begin
        n_rise++;
        rise_cyc = cyc;
      end
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        res_hs_cyc = cyc;
        n_res++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_product", res_product, e.prod);
          check("res_err", {63'd0, res_err}, {63'd0, e.err});
        end
      end
    end
  end

  // Drive a command and hold it until accepted; queue the expected result.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic e_err);
    exp_t e;
    bit ok = 0;
    cmd_valid = 1; cmd_op_a = a; cmd_op_b = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
    else begin
      acc_cyc = cyc;
      e.prod = e_err ? 64'd0 : ({32'd0, a} * {32'd0, b});
      e.err  = e_err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_res(input int target);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (n_res >= target) ok = 1;
    end
    if (!ok) check("result_timeout", 64'(n_res), 64'(target));
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wstrb_q.delete(); rd_addr_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin : main
    int base, hs_before, ar_before, rise_before;
    bit seen;
    aresetn = 0; cmd_valid = 0; cmd_op_a = 0; cmd_op_b = 0; res_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_valids", {58'd0, awvalid, wvalid, arvalid, res_valid, bready, rready}, 64'd0);
    check("rst_awaddr", {56'd0, awaddr}, 64'd0);
    check("rst_wdata", {32'd0, wdata}, 64'd0);
    check("rst_wstrb", {60'd0, wstrb}, 64'd0);
    check("rst_araddr", {56'd0, araddr}, 64'd0);
    check("rst_product", res_product, 64'd0);
    check("rst_err", {63'd0, res_err}, 64'd0);
    aresetn = 1;
    @(posedge clk); #1;

    // Test 1: zero-wait slave, ordering and minimum latency
    clear_logs();
    base = n_res;
    send_cmd(32'h278, 32'h1468, 1'b0);
    wait_res(base + 1);
    check("t1_latency", 64'(rise_cyc - acc_cyc), 64'd9);
    check("t1_wr_count", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check("t1_wr0_addr", {56'd0, wr_addr_q[0]}, 64'd16);
      check("t1_wr0_data", {32'd0, wr_data_q[0]}, 64'h278);
      check("t1_wr1_addr", {56'd0, wr_addr_q[1]}, 64'd20);
      check("t1_wr1_data", {32'd0, wr_data_q[1]}, 64'h1468);
      check("t1_wstrb", {60'd0, wstrb_q[0]}, 64'hF);
    end
    check("t1_rd_count", 64'(rd_addr_q.size()), 64'd2);
    if (rd_addr_q.size() == 2) begin
      check("t1_rd0_addr", {56'd0, rd_addr_q[0]}, 64'd24);
      check("t1_rd1_addr", {56'd0, rd_addr_q[1]}, 64'd28);
    end

    // Test 2: awready held off 3 cycles, wready immediate
    @(posedge clk); #1;
    aw_delay = 3;
    base = n_res;
    send_cmd(32'h1234, 32'h10, 1'b0);
    @(negedge clk);
    check("t2_c1_vld", {62'd0, awvalid, wvalid}, 64'h3);
    check("t2_c1_bready", {63'd0, bready}, 64'd0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check("t2_wvalid_dropped", {63'd0, wvalid}, 64'd0);
      check("t2_awvalid_held", {63'd0, awvalid}, 64'd1);
      check("t2_awaddr_stable", {56'd0, awaddr}, 64'd16);
      check("t2_no_bready", {63'd0, bready}, 64'd0);
    end
    @(negedge clk);
    check("t2_bready_after", {63'd0, bready}, 64'd1);
    wait_res(base + 1);
    aw_delay = 0;

    // Test 3: error response on operand B write
    @(posedge clk); #1;
    clear_logs();
    err_addr = 8'd20;
    ar_before = ar_count;
    base = n_res;
    send_cmd(32'h55, 32'h66, 1'b1);
    wait_res(base + 1);
    check("t3_no_ar", 64'(ar_count - ar_before), 64'd0);
    err_addr = 8'hFF;

    // Test 4: slow read data and a stalled result handshake
    @(posedge clk); #1;
    r_delay = 5;
    res_ready = 0;
    base = n_res;
    fork
      begin
        send_cmd(32'd100, 32'd200, 1'b0);
        send_cmd(32'd9, 32'd9, 1'b0);
        check("t4_accept_after_hs", 64'(acc_cyc - res_hs_cyc), 64'd1);
      end
      begin
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (res_valid) seen = 1;
        end
        if (!seen) check("t4_res_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          check("t4_hold_product", res_product, 64'd20000);
          check("t4_hold_valid", {63'd0, res_valid}, 64'd1);
          check("t4_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1;
      end
    join
    wait_res(base + 2);
    r_delay = 0;

    // Test 5: reset while in RD_LO
    @(posedge clk); #1;
    send_cmd(32'd11, 32'd13, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (arvalid) seen = 1;
    end
    check("t5_reached_rd_lo", {63'd0, seen}, 64'd1);
    rise_before = n_rise;
    hs_before = n_res;
    aresetn = 0;
    @(posedge clk); #1;
    check("t5_valids_cleared", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
    check("t5_res_valid", {63'd0, res_valid}, 64'd0);
    check("t5_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    aresetn = 1;
    exp_q.delete();
    repeat (6) @(negedge clk);
    check("t5_no_partial", 64'(n_rise - rise_before), 64'd0);
    check("t5_no_result_hs", 64'(n_res - hs_before), 64'd0);
    @(posedge clk); #1;
    base = n_res;
    send_cmd(32'd3, 32'd5, 1'b0);
    wait_res(base + 1);

    // Test 6: back-to-back commands
    @(posedge clk); #1;
    base = n_res;
    send_cmd(32'hFFFFFFFF, 32'd2, 1'b0);
    send_cmd(32'd7, 32'd6, 1'b0);
    wait_res(base + 2);
    check("t6_queue_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_axi_master.md
# mult_axi_master

AXI-Lite initiator that drives the memory-mapped multiplier slave from a simple command interface. Accepting one command, it writes operand A and operand B to the multiplier's operand registers, then reads the low and high result words back. It returns the concatenated product, or an error flag, on a valid/ready result port. It sits between a local sequencer and the multiplier's s2_axi slave port; no other glue is required.

## Interface
- DATA_WIDTH, 32, AXI data width and operand width
- ADDR_WIDTH, 8, AXI address width
- ADDR_OP_A, 16, byte address of operand A register
- ADDR_OP_B, 20, byte address of operand B register
- ADDR_RES_LO, 24, byte address of result low word
- ADDR_RES_HI, 28, byte address of result high word

Ports:
- m2_axi_aclk  in  1  sole clock; all logic rising-edge
- m2_axi_aresetn  in  1  synchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_op_a, cmd_op_b  in  DATA_WIDTH each  operands
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_product  out  2*DATA_WIDTH  {RES_HI word, RES_LO word}
- res_err  out  1  a bresp or rresp was nonzero
- m2_axi_awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1
- m2_axi_wdata / wstrb / wvalid / wready  out / out / out / in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1
- m2_axi_bresp / bvalid / bready  in / in / out  1 / 1 / 1  (bresp nonzero = error)
- m2_axi_araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1
- m2_axi_rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 1 / 1 / 1

## Operation
- FSM states: IDLE, WR_A, WR_A_RESP, WR_B, WR_B_RESP, RD_LO, RD_LO_DATA, RD_HI, RD_HI_DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch both operands and go to WR_A.
- WR_A/WR_B: awvalid and wvalid assert together with awaddr=ADDR_OP_x, wdata=operand, and wstrb all ones.
  - Each valid drops independently on its own handshake.
  - The state advances to *_RESP once both AW and W have completed, in either order or in the same cycle.
- *_RESP: bready=1. On bvalid, go to the next state; bresp≠0 sets the err latch and jumps to DONE.
- RD_LO/RD_HI: arvalid=1 with araddr=ADDR_RES_x. On arready, go to *_DATA.
- *_DATA: rready=1. On rvalid, capture rdata into the lo/hi half; rresp≠0 sets err and jumps to DONE.
- DONE: res_valid=1, holding res_product and res_err. On res_ready, go to IDLE and clear err.
- On error, res_product holds whatever was captured so far, with uncaptured halves at 0.
- Valids never depend combinationally on the matching ready. Address and data stay stable while valid=1 and ready=0.
- Only one transaction is outstanding at any time. Writes and reads never overlap.

## Timing
- Reset values: every valid and ready output is 0 except cmd_ready=1. awaddr, wdata, araddr, and res_product are 0; wstrb is 0; res_err is 0; FSM is in IDLE.
- Reset mid-operation: the next edge drops all valids, returns to IDLE, and emits no partial result. The slave is expected to be reset alongside.
- Minimum latency with an always-ready slave answering in the next cycle: command handshake at cycle 0 gives res_valid at cycle 9.
  - WR_A is at cycle 1; each state then takes 1 cycle.
- cmd_ready is 0 from the cycle after acceptance until the cycle after res_ready is taken.
- Back-to-back: res_ready in DONE returns to IDLE. The next command can be accepted one cycle later.
- Stalls are unbounded; there is no timeout.

## Structure
- Shared package mult_axi_pkg holds:
  - the FSM state encoding
  - the default register offsets 16/20/24/28
  - the OKAY response constant 0
- One natural sub-module, axi_lite_wr_channel. It drives AW+W with independent drop-on-handshake and signals done, and is instantiated once and reused for both writes.
- Everything else stays flat.

## Test plan
- Slave model always ready; command A=0x278, B=0x1468; model returns lo=0x003260C0, hi=0 → writes observed to 16 then 20 with the correct data, reads from 24 then 28, res_product=0x00000000003260C0, res_err=0, res_valid at cycle 9.
- awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid holds with awaddr=16 stable, and no B accept occurs before both handshakes complete.
- bresp=1 on the operand B write → no AR is issued, res_err=1, res_product=0.
- rvalid delayed 5 cycles, res_ready low for 4 cycles in DONE → res_product stays stable throughout, cmd_ready=0, and the next command is accepted only after the result handshake.
- Reset asserted while in RD_LO → all valids are 0 after the next edge, cmd_ready=1, res_valid never rises. A new command A=3, B=5 with model lo=15 yields res_product=15.
- Two back-to-back commands, (0xFFFFFFFF, 2) then (7, 6), with model results hi=1, lo=0xFFFFFFFE then 42 → res_product=0x1FFFFFFFE then 42 (0x2A), in order.
